// File: rtl/vga_dither_pkg.sv
// rtl/vga_dither_pkg.sv - shared modes, Bayer matrix and LFSR defaults for the VGA ditherer
package vga_dither_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC = 2'd0,
    MODE_ROUND = 2'd1,
    MODE_RAND  = 2'd2,
    MODE_BAYER = 2'd3
  } mode_e;

  // Entry (y*4+x) lives in nibble y*4+x; rows 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5
  localparam logic [63:0] BAYER_4X4 = 64'h5D7F_91B3_6E4C_A280;

  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'hA300_0000;

  function automatic logic [3:0] bayer_at(input logic [1:0] y, input logic [1:0] x);
    return BAYER_4X4[{y, x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/vga_dither_lfsr.sv
// rtl/vga_dither_lfsr.sv - free-running Fibonacci LFSR, shifts left with XOR-of-taps into the LSB
module vga_dither_lfsr
  import vga_dither_pkg::*;
#(
  parameter int                 LFSR_W    = 32,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '1;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/vga_dither_core.sv
// rtl/vga_dither_core.sv - two-stage colour depth reducer: truncate, round, random or Bayer dither
module vga_dither_core
  import vga_dither_pkg::*;
#(
  parameter int                IN_W      = 8,
  parameter int                OUT_W     = 4,
  parameter int                CH        = 3,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH*IN_W-1:0]        pix_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      de_in,
  input  logic [1:0]                mode_req,
  input  logic [$clog2(IN_W)-1:0]   depth_req,
  output logic [CH*OUT_W-1:0]       pix_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      de_out
);

  localparam int F  = IN_W - OUT_W;
  localparam int DW = $clog2(IN_W);

  // Keep the top min(d+1, IN_W) bits and repeat them MSB-first down to bit 0
  function automatic logic [IN_W-1:0] expand(input logic [IN_W-1:0] p, input logic [DW-1:0] d);
    int k;
    logic [IN_W-1:0] t;
    k = (int'(d) + 1 > IN_W) ? IN_W : int'(d) + 1;
    for (int i = 0; i < IN_W; i++) begin
      t[i] = p[IN_W-1 - ((IN_W-1-i) % k)];
    end
    return t;
  endfunction

  logic [LFSR_W-1:0] lfsr;

  vga_dither_lfsr #(
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .lfsr(lfsr)
  );

  logic          vs_d;
  logic          de_d;
  logic          vs_rise;
  logic          de_fall;
  mode_e         active_mode;
  logic [DW-1:0] active_depth;
  logic [1:0]    x_cnt;
  logic [1:0]    y_cnt;

  assign vs_rise = vsync_in & ~vs_d;
  assign de_fall = de_d & ~de_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      x_cnt        <= 2'd0;
      y_cnt        <= 2'd0;
      active_mode  <= MODE_TRUNC;
      active_depth <= DW'(IN_W-1);
    end else begin
      vs_d <= vsync_in;
      de_d <= de_in;
      if (vs_rise) begin
        active_mode  <= mode_e'(mode_req);
        active_depth <= depth_req;
      end
      if (de_in) begin
        x_cnt <= x_cnt + 2'd1;
      end else if (de_fall) begin
        x_cnt <= 2'd0;
      end
      // A frame start overrides the end-of-line increment
      if (vs_rise) begin
        y_cnt <= 2'd0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + 2'd1;
      end
    end
  end

  logic [CH*IN_W-1:0] pix_s1;
  logic               hs_s1;
  logic               vs_s1;
  logic               de_s1;
  mode_e              mode_s1;
  logic [DW-1:0]      depth_s1;
  logic [1:0]         x_s1;
  logic [1:0]         y_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1   <= '0;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      de_s1    <= 1'b0;
      mode_s1  <= MODE_TRUNC;
      depth_s1 <= '0;
      x_s1     <= 2'd0;
      y_s1     <= 2'd0;
    end else begin
      pix_s1   <= pix_in;
      hs_s1    <= hsync_in;
      vs_s1    <= vsync_in;
      de_s1    <= de_in;
      mode_s1  <= active_mode;
      depth_s1 <= active_depth;
      x_s1     <= x_cnt;
      y_s1     <= y_cnt;
    end
  end

  // Shifting {B, F zeros} right by 4 scales the 4-bit Bayer value to F bits either way
  logic [F+3:0] bayer_wide;
  logic [F-1:0] bayer_thr;

  assign bayer_wide = {bayer_at(y_s1, x_s1), {F{1'b0}}} >> 4;
  assign bayer_thr  = bayer_wide[F-1:0];

  logic [CH*OUT_W-1:0] pix_next;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [IN_W-1:0]  t;
    logic [OUT_W-1:0] hi;
    logic [F-1:0]     frac;
    logic [F-1:0]     rnd_thr;
    logic             bump;
    logic [OUT_W:0]   sum;

    assign t       = expand(pix_s1[c*IN_W +: IN_W], depth_s1);
    assign hi      = t[IN_W-1:F];
    assign frac    = t[F-1:0];
    assign rnd_thr = lfsr[8*c +: F];

    always_comb begin
      bump = 1'b0;
      case (mode_s1)
        MODE_TRUNC: bump = 1'b0;
        MODE_ROUND: bump = frac[F-1];
        MODE_RAND:  bump = (frac > rnd_thr);
        MODE_BAYER: bump = (frac > bayer_thr);
        default:    bump = 1'b0;
      endcase
    end

    assign sum = {1'b0, hi} + {{OUT_W{1'b0}}, bump};
    assign pix_next[c*OUT_W +: OUT_W] = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
  end

  logic lfsr_unused;
  assign lfsr_unused = ^{lfsr, bayer_wide};

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out   <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      pix_out   <= de_s1 ? pix_next : '0;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      de_out    <= de_s1;
    end
  end

endmodule

// File: tb/tb_vga_dither_core.sv
// tb/tb_vga_dither_core.sv - scoreboard bench for vga_dither_core at default parameters
module tb_vga_dither_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_in;
  logic        hsync_in, vsync_in, de_in;
  logic [1:0]  mode_req;
  logic [2:0]  depth_req;
  logic [11:0] pix_out;
  logic        hsync_out, vsync_out, de_out;

  always #5 clk = ~clk;

  vga_dither_core dut (
    .clk      (clk),
    .rst      (rst),
    .pix_in   (pix_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .mode_req (mode_req),
    .depth_req(depth_req),
    .pix_out  (pix_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .de_out   (de_out)
  );

  typedef struct {
    int          cyc;
    logic [14:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   lfsr_chk_cyc = -1;
  bit   rand_on = 1'b0;
  int   rand_ones = 0;
  logic [31:0] rand_sig = '0;

  logic [1:0] m_mode;
  logic [2:0] m_depth;
  int         m_x, m_y;
  logic       m_vs_prev, m_de_prev;
  int         bayer_tb[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  function automatic logic [3:0] model_chan(input logic [7:0] p);
    int k, filled, hi, frac, bump;
    logic [15:0] acc;
    logic [7:0] top, t;
    k = (m_depth >= 3'd7) ? 8 : int'(m_depth) + 1;
    top = p >> (8 - k);
    acc = '0;
    filled = 0;
    while (filled < 8) begin
      acc = (acc << k) | {8'h00, top};
      filled += k;
    end
    t = 8'(acc >> (filled - 8));
    hi = int'(t[7:4]);
    frac = int'(t[3:0]);
    case (m_mode)
      2'd1:    bump = (frac >= 8) ? 1 : 0;
      2'd3:    bump = (frac > bayer_tb[(m_y % 4) * 4 + (m_x % 4)]) ? 1 : 0;
      default: bump = 0;
    endcase
    return (hi + bump > 15) ? 4'hF : 4'(hi + bump);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (lfsr_chk_cyc == cyc) check_eq("lfsr_after_rst", dut.lfsr, 32'hFFFF_FFFF);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_eq({"stale_", e.tag}, e.cyc, cyc);
      else check_eq(e.tag, {17'h0, hsync_out, vsync_out, de_out, pix_out}, {17'h0, e.v});
    end
    if (rand_on && de_out) begin
      for (int c = 0; c < 3; c++) if (pix_out[4*c +: 4] == 4'd1) rand_ones++;
      rand_sig = {rand_sig[30:0], rand_sig[31]} ^ {20'h0, pix_out};
    end
  end

  task automatic step(input logic [23:0] pix, input logic hs, input logic vs, input logic de,
                      input bit chk, input string tag);
    exp_t e;
    logic [11:0] ep;
    logic vr, df;
    @(posedge clk); #1;
    rst = 1'b0;
    pix_in = pix; hsync_in = hs; vsync_in = vs; de_in = de;
    if (chk) begin
      for (int c = 0; c < 3; c++) ep[4*c +: 4] = de ? model_chan(pix[8*c +: 8]) : 4'h0;
      e.cyc = cyc + 2; e.v = {hs, vs, de, ep}; e.tag = tag;
      sb.push_back(e);
    end
    vr = vs & ~m_vs_prev;
    df = ~de & m_de_prev;
    if (vr) begin m_mode = mode_req; m_depth = depth_req; end
    if (de) m_x++; else if (df) m_x = 0;
    if (vr) m_y = 0; else if (df) m_y++;
    m_vs_prev = vs; m_de_prev = de;
  endtask

  task automatic pulse_rst(input logic [23:0] pix);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1; pix_in = pix; hsync_in = 1'b1; vsync_in = 1'b0; de_in = 1'b1;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    e.v = '0; e.tag = "rst_flush";
    e.cyc = cyc + 1; sb.push_back(e);
    e.cyc = cyc + 2; sb.push_back(e);
    lfsr_chk_cyc = cyc + 1;
    m_mode = 2'd0; m_depth = 3'd7; m_x = 0; m_y = 0; m_vs_prev = 1'b0; m_de_prev = 1'b0;
  endtask

  task automatic line(input logic [23:0] pix, input int n, input string tag);
    for (int i = 0; i < n; i++) step(pix, 1'b0, 1'b0, 1'b1, 1'b1, tag);
    repeat (2) step(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, "hblank");
  endtask

  task automatic new_frame(input logic [1:0] m, input logic [2:0] d);
    mode_req = m; depth_req = d;
    repeat (2) step(24'h0, 1'b0, 1'b1, 1'b0, 1'b1, "vsync");
    repeat (2) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "vback");
  endtask

  task automatic rand_run(output int ones, output logic [31:0] sig);
    pulse_rst(24'h0);
    new_frame(2'd2, 3'd7);
    rand_ones = 0; rand_sig = '0; rand_on = 1'b1;
    repeat (4096) step(24'h040404, 1'b0, 1'b0, 1'b1, 1'b0, "");
    repeat (4) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, "");
    rand_on = 1'b0;
    ones = rand_ones; sig = rand_sig;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones1, ones2;
    logic [31:0] sig1, sig2;
    pix_in = 24'hFFFFFF; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b1;
    mode_req = 2'd3; depth_req = 3'd0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", {17'h0, hsync_out, vsync_out, de_out, pix_out}, 32'h0);
    check_eq("rst_lfsr", dut.lfsr, 32'hFFFF_FFFF);
    m_mode = 2'd0; m_depth = 3'd7; m_x = 0; m_y = 0; m_vs_prev = 1'b0; m_de_prev = 1'b0;
    mode_req = 2'd0; depth_req = 3'd7;

    step(24'hA7A7A7, 1'b1, 1'b0, 1'b1, 1'b1, "trunc_a7");
    step(24'h5CFF00, 1'b1, 1'b0, 1'b1, 1'b1, "trunc_mix");
    step(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, "blank");
    step(24'h123456, 1'b1, 1'b0, 1'b1, 1'b1, "trunc_123456");

    mode_req = 2'd1;
    line(24'h181818, 3, "midframe_still_trunc");
    new_frame(2'd1, 3'd7);
    line(24'h181818, 2, "round_18");
    line(24'hF91718, 2, "round_mix_sat");

    new_frame(2'd3, 3'd7);
    repeat (5) line(24'h0C0804, 6, "bayer");

    new_frame(2'd0, 3'd0);
    line(24'hC04080, 2, "depth0");
    new_frame(2'd1, 3'd3);
    line(24'h9F9F9F, 2, "depth3_round");

    new_frame(2'd1, 3'd7);
    repeat (2) step(24'h181818, 1'b0, 1'b0, 1'b1, 1'b1, "pre_rst");
    pulse_rst(24'h181818);
    repeat (3) step(24'h181818, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst_trunc");
    repeat (2) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_blank");

    rand_run(ones1, sig1);
    rand_run(ones2, sig2);
    check_eq("rand_ratio_run1", {31'h0, (ones1 >= 2704 && ones1 <= 3440)}, 32'h1);
    check_eq("rand_ratio_run2", {31'h0, (ones2 >= 2704 && ones2 <= 3440)}, 32'h1);
    check_eq("rand_repeat_count", ones2, ones1);
    check_eq("rand_repeat_sig", sig2, sig1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) check_eq("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_dither_core.md
VGA_DITHER_CORE -- requirements
Module: vga_dither_core

Interface
REQ-001 Parameter IN_W, default 8: per-channel input colour width; SHALL satisfy IN_W > OUT_W.
REQ-002 Parameter OUT_W, default 4: per-channel output colour width.
REQ-003 Parameter CH, default 3: number of colour channels, with channel 0 in the LSBs.
REQ-004 Parameter LFSR_W, default 32: LFSR width; SHALL satisfy LFSR_W >= 8*CH.
REQ-005 Parameter LFSR_TAPS, default 32'hA3000000 (taps at bits 31,29,25,24): feedback mask.
REQ-006 Derived constant F = IN_W-OUT_W: fraction width; SHALL satisfy 1 <= F <= 8.
REQ-007 Port clk, input, width 1: the single clock; all logic SHALL be on its rising edge.
REQ-008 Port rst, input, width 1: reset, synchronous, active-high.
REQ-009 Port pix_in, input, width CH*IN_W: input pixel.
REQ-010 Port hsync_in, vsync_in, de_in, inputs, width 1 each: input timing; vsync is active-high; de high means visible pixel.
REQ-011 Port mode_req, input, width 2: requested mode (0 truncate, 1 round, 2 random dither, 3 ordered Bayer).
REQ-012 Port depth_req, input, width $clog2(IN_W): requested effective input depth, value d meaning d+1 MSBs.
REQ-013 Port pix_out, output, width CH*OUT_W: dithered pixel.
REQ-014 Port hsync_out, vsync_out, de_out, outputs, width 1 each: timing delayed to match pix_out.

Function
REQ-015 Inputs to outputs SHALL have a fixed latency of 2 clk for pixel, hsync, vsync and de.
REQ-016 active_mode/active_depth SHALL load mode_req/depth_req only on the cycle vsync_in rises (registered edge detect); a change mid-frame SHALL take effect at the next frame.
REQ-017 Depth expansion: keep the top min(d+1, IN_W) bits of each channel and replicate them MSB-first to fill IN_W bits (value t); d >= IN_W-1 SHALL pass the input through unchanged.
REQ-018 hi = t[IN_W-1:F] and frac = t[F-1:0].
REQ-019 Output value = hi + bump, saturating at 2^OUT_W-1, with no wrap.
REQ-020 Mode 0: bump = 0.
REQ-021 Mode 1: bump = (frac >= 2^(F-1)).
REQ-022 Mode 2: bump = (frac > thr_c), where thr_c = lfsr[8*c +: F] for channel c.
REQ-023 Mode 3: bump = (frac > thr), where thr is a 4-bit Bayer value B[y%4][x%4] shared by all channels.
REQ-024 Mode 3 scaling: if F >= 4, thr = {B, (F-4) zeros}; if F < 4, thr = B[3:4-F].
REQ-025 Bayer rows SHALL be: 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
REQ-026 x counter: increments on every de_in cycle; clears on the cycle after de_in falls.
REQ-027 y counter: increments on each de_in falling edge; clears when vsync_in rises.
REQ-028 Both counters SHALL be 2 bits wide and wrap freely.
REQ-029 LFSR: Fibonacci, shifting left each cycle, with new LSB = XOR of the bits selected by LFSR_TAPS.
REQ-030 The LFSR SHALL advance every non-reset cycle regardless of de.
REQ-031 When the delayed de is 0, pix_out SHALL be 0 (blanking).
REQ-032 Simultaneous vsync rise and de fall: the y counter clear SHALL win.

Reset
REQ-033 While rst is high, the following SHALL be 0 on the next edge: pix_out, hsync_out, vsync_out, de_out, the pipeline registers, the x/y counters and the edge-detect registers.
REQ-034 While rst is high, the LFSR SHALL load all ones, active_mode SHALL load 0 and active_depth SHALL load IN_W-1.
REQ-035 Reset mid-line SHALL abandon pixels in flight, and output SHALL resume 2 clk after the first non-reset cycle.

Structure
REQ-036 Package vga_dither_pkg SHALL hold: the mode enum (MODE_TRUNC, MODE_ROUND, MODE_RAND, MODE_BAYER), the Bayer 4x4 constant and the default LFSR taps.
REQ-037 Sub-module vga_dither_lfsr, parameterised by LFSR_W and LFSR_TAPS, SHALL contain the LFSR.
REQ-038 Per-channel logic SHALL be a generate loop over CH.

Verification
REQ-039 Defaults, mode 0, depth 7: pix_in channel = 0xA7 with de=1 -> channel out 0xA exactly 2 clk later, with syncs aligned.
REQ-040 Mode 1: 0x18 -> 0x2; 0x17 -> 0x1; 0xF9 -> 0xF (saturate).
REQ-041 Mode 3: constant 0x08 over a 4x4 region -> output 1 exactly where B < 8 (8 of 16 pixels), else 0; pattern repeats every 4 pixels/lines.
REQ-042 Mode 2: constant 0x04 for 4096 de cycles -> fraction of outputs equal to 1 lies in 25% +/- 3%; after rst, the sequence is identical run-to-run.
REQ-043 mode_req changed 0->1 mid-frame -> output stays truncated until the cycle after the next vsync_in rise.
REQ-044 Depth 0 with channel 0x80 -> t = 0xFF -> out 0xF; a 1-cycle rst pulse mid-line -> all outputs 0 on the next edge and LFSR = all ones.
